// File: rtl/uart_echo_tester_if.sv
// ============================================================================
//  Module   : uart_echo_tester_if
//  Purpose  : Byte-level link between the echo tester and the 8N1 tx/rx pair.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_echo_tester_if;
   logic [7:0] tx_data;
   logic       tx_send;
   logic       tx_busy;
   logic [7:0] rx_data;
   logic       rx_ready;

   modport master (
      output tx_data,
      output tx_send,
      input  tx_busy,
      input  rx_data,
      input  rx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_send,
      output tx_busy,
      output rx_data,
      output rx_ready
   );
endinterface

`default_nettype wire

// File: rtl/uart_echo_tester.sv
// ============================================================================
//  Module   : uart_echo_tester
//  Purpose  : Sends an incrementing byte sequence, checks each echo, and counts
//             mismatches plus timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_echo_tester #(
   parameter int         TIMEOUT_CYCLES = 60000,
   parameter logic [7:0] SEED           = 8'h00
) (
   input  logic               hwclk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [15:0]        num_bytes,
   uart_echo_tester_if.master uart,
   output logic               running,
   output logic               done,
   output logic               pass,
   output logic [15:0]        err_count,
   output logic [15:0]        sent_count,
   output logic               led
);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_send   = 3'd1;
   localparam logic [2:0] c_st_wait   = 3'd2;
   localparam logic [2:0] c_st_check  = 3'd3;
   localparam logic [2:0] c_st_finish = 3'd4;

   localparam int            c_cw      = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [c_cw-1:0] c_to_last = c_cw'(TIMEOUT_CYCLES - 1);

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [15:0]     r_count_lat;
   logic [c_cw-1:0] r_to_cnt;
   logic [c_cw-1:0] w_to_inc;
   logic            w_to_hit;
   logic [1:0]      r_sync;
   logic            r_sync_q;
   logic            r_rx_edge;
   logic [7:0]      r_rx_byte;
   logic            r_timed_out;
   logic [7:0]      r_tx_data;
   logic            w_tx_send;
   logic [15:0]     w_err_inc;

   // Counter is cleared on send, so the incremented value reaching the terminal
   // count places CHECK exactly TIMEOUT_CYCLES after the send cycle.
   assign w_to_inc  = r_to_cnt + 1'b1;
   assign w_to_hit  = (w_to_inc == c_to_last);
   assign w_err_inc = (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;

   assign uart.tx_data = r_tx_data;
   assign uart.tx_send = w_tx_send;

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (start) begin
               w_next = (num_bytes == 16'd0) ? c_st_finish : c_st_send;
            end
         end
         c_st_send: begin
            if (!uart.tx_busy) begin
               w_next = c_st_wait;
            end
         end
         c_st_wait: begin
            if (r_rx_edge || w_to_hit) begin
               w_next = c_st_check;
            end
         end
         c_st_check: begin
            w_next = (sent_count == r_count_lat) ? c_st_finish : c_st_send;
         end
         c_st_finish: w_next = c_st_idle;
         default:     w_next = c_st_idle;
      endcase
   end

   always_comb begin
      w_tx_send = (r_state == c_st_send) && !uart.tx_busy;
   end

   always_ff @(posedge hwclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync      <= 2'b00;
         r_sync_q    <= 1'b0;
         r_rx_edge   <= 1'b0;
         r_rx_byte   <= 8'h00;
         r_timed_out <= 1'b0;
         r_to_cnt    <= '0;
         r_count_lat <= 16'd0;
         r_tx_data   <= SEED;
         running     <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err_count   <= 16'd0;
         sent_count  <= 16'd0;
         led         <= 1'b0;
      end else begin
         r_sync    <= {r_sync[0], uart.rx_ready};
         r_sync_q  <= r_sync[1];
         r_rx_edge <= r_sync[1] & ~r_sync_q;
         done      <= (r_state == c_st_finish);
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_count_lat <= num_bytes;
                  err_count   <= 16'd0;
                  sent_count  <= 16'd0;
                  pass        <= 1'b0;
                  r_tx_data   <= SEED;
                  running     <= 1'b1;
               end
            end
            c_st_send: begin
               if (w_tx_send) begin
                  sent_count <= sent_count + 16'd1;
                  r_to_cnt   <= '0;
               end
            end
            c_st_wait: begin
               // An echo edge on the terminal-count cycle takes priority.
               if (r_rx_edge) begin
                  r_rx_byte   <= uart.rx_data;
                  r_timed_out <= 1'b0;
               end else begin
                  r_to_cnt <= w_to_inc;
                  if (w_to_hit) begin
                     r_timed_out <= 1'b1;
                     err_count   <= w_err_inc;
                  end
               end
            end
            c_st_check: begin
               if (!r_timed_out) begin
                  if (r_rx_byte != r_tx_data) begin
                     err_count <= w_err_inc;
                  end else begin
                     led <= ~led;
                  end
               end
               if (sent_count != r_count_lat) begin
                  r_tx_data <= r_tx_data + 8'd1;
               end
            end
            c_st_finish: begin
               pass    <= (err_count == 16'd0);
               running <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_echo_tester.sv
// ============================================================================
//  Module   : tb_uart_echo_tester
//  Purpose  : Randomized echo-responder bench with a run-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_echo_tester;

   localparam int         c_to   = 100;
   localparam logic [7:0] c_seed = 8'hFE;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] num_bytes = 16'd0;
   logic        running, done, pass, led;
   logic [15:0] err_count, sent_count;

   uart_echo_tester_if u ();

   uart_echo_tester #(
      .TIMEOUT_CYCLES (c_to),
      .SEED           (c_seed)
   ) dut (
      .hwclk      (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_bytes  (num_bytes),
      .uart       (u),
      .running    (running),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .sent_count (sent_count),
      .led        (led)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   // Per-byte echo plan: 0 good echo, 1 corrupted echo, 2 no echo (timed), 3 silent
   int   plan [0:63];
   int   resp_idx = 0;
   int   chk_idx = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   int   done_cyc = 0;
   int   exp_n = 0;
   int   exp_err = 0;
   logic exp_led = 1'b0;
   logic exp_led_final = 1'b0;
   bit   busy_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (u.tx_send) begin
         chk("busy_at_send", {31'd0, u.tx_busy}, 0);
         chk("tx_byte", {24'd0, u.tx_data}, {24'd0, 8'(c_seed + chk_idx)});
         chk("sent_at_send", {16'd0, sent_count}, chk_idx);
         chk("running_at_send", {31'd0, running}, 1);
         chk_idx++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         chk("done_err", {16'd0, err_count}, exp_err);
         chk("done_pass", {31'd0, pass}, (exp_err == 0) ? 1 : 0);
         chk("done_sent", {16'd0, sent_count}, exp_n);
         chk("done_led", {31'd0, led}, {31'd0, exp_led_final});
         chk("done_running", {31'd0, running}, 0);
         exp_led = exp_led_final;
      end
   end

   initial begin
      int  left;
      bit  s;
      left = 0;
      u.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         s = u.tx_send;
         @(posedge clk);
         #1;
         if (s && busy_en) left = $urandom_range(0, 30);
         u.tx_busy = (left > 0);
         if (left > 0) left--;
      end
   end

   initial begin
      logic [7:0]  b;
      logic [15:0] e0;
      int          m, d;
      u.rx_ready = 1'b0;
      u.rx_data  = 8'h00;
      forever begin
         @(negedge clk);
         if (u.tx_send) begin
            b = u.tx_data;
            m = plan[resp_idx];
            resp_idx++;
            e0 = err_count;
            if (m == 0 || m == 1) begin
               d = $urandom_range(2, 40);
               repeat (d) @(posedge clk);
               #1;
               u.rx_data  = b ^ ((m == 1) ? 8'h01 : 8'h00);
               u.rx_ready = 1'b1;
               repeat (3) @(posedge clk);
               #1;
               u.rx_ready = 1'b0;
            end else if (m == 2) begin
               repeat (c_to - 1) @(negedge clk);
               chk("no_early_timeout", {16'd0, err_count}, {16'd0, e0});
               @(negedge clk);
               chk("timeout_at_T", {16'd0, err_count}, {16'd0, e0} + 1);
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_tx_data"}, {24'd0, u.tx_data}, {24'd0, c_seed});
      chk({tag, "_tx_send"}, {31'd0, u.tx_send}, 0);
      chk({tag, "_running"}, {31'd0, running}, 0);
      chk({tag, "_done"}, {31'd0, done}, 0);
      chk({tag, "_pass"}, {31'd0, pass}, 0);
      chk({tag, "_err"}, {16'd0, err_count}, 0);
      chk({tag, "_sent"}, {16'd0, sent_count}, 0);
      chk({tag, "_led"}, {31'd0, led}, 0);
   endtask

   // kind: 0 all good, 1 random mix, 2 all timeouts, 4 corrupt byte index 2
   task automatic run_test(input int n, input int kind, input bit restart, input bit check_first);
      int ok, d0, start_cyc, r;
      ok = 0;
      exp_err = 0;
      for (int i = 0; i < n; i++) begin
         case (kind)
            1: begin
               r = $urandom_range(0, 9);
               plan[i] = (r < 7) ? 0 : (r < 9) ? 1 : 2;
            end
            2:       plan[i] = 2;
            4:       plan[i] = (i == 2) ? 1 : 0;
            default: plan[i] = 0;
         endcase
         if (plan[i] == 0) ok++;
         else exp_err++;
      end
      exp_n = n;
      exp_led_final = exp_led ^ ok[0];
      resp_idx = 0;
      chk_idx = 0;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      num_bytes = 16'(n);
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (check_first) begin
         @(negedge clk);
         chk("send_at_start_plus1", {31'd0, u.tx_send}, 1);
      end
      if (restart) begin
         repeat (20) @(posedge clk);
         #1;
         num_bytes = 16'd7;
         start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
      end
      for (int k = 0; k < n * (c_to + 60) + 40 && done_cnt == d0; k++) begin
         @(posedge clk);
         #1;
      end
      chk("done_once", done_cnt - d0, 1);
      chk("sends_seen", chk_idx, n);
      if (n == 0) chk("done_latency_n0", done_cyc - start_cyc, 2);
      repeat (3) @(posedge clk);
      #1;
      chk("pass_held", {31'd0, pass}, (exp_err == 0) ? 1 : 0);
      chk("done_single_cycle", {31'd0, done}, 0);
   endtask

   initial begin
      int          d0;
      logic [15:0] e_save;
      logic        l_save;
      for (int i = 0; i < 64; i++) plan[i] = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");

      run_test(0, 0, 1'b0, 1'b0);
      busy_en = 1'b0;
      run_test(4, 0, 1'b0, 1'b1);
      chk("lit_wrap_err", {16'd0, err_count}, 0);
      chk("lit_wrap_sent", {16'd0, sent_count}, 4);
      chk("lit_wrap_led", {31'd0, led}, 0);
      chk("lit_wrap_pass", {31'd0, pass}, 1);
      busy_en = 1'b1;

      run_test(5, 4, 1'b0, 1'b0);
      chk("lit_corrupt_err", {16'd0, err_count}, 1);
      chk("lit_corrupt_pass", {31'd0, pass}, 0);
      chk("lit_corrupt_sent", {16'd0, sent_count}, 5);

      run_test(3, 2, 1'b0, 1'b0);
      chk("lit_timeout_err", {16'd0, err_count}, 3);

      run_test(6, 0, 1'b1, 1'b0);
      chk("lit_restart_sent", {16'd0, sent_count}, 6);

      e_save = err_count;
      l_save = led;
      @(posedge clk);
      #1;
      u.rx_data  = 8'h55;
      u.rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      u.rx_ready = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("stray_err", {16'd0, err_count}, {16'd0, e_save});
      chk("stray_led", {31'd0, led}, {31'd0, l_save});
      chk("stray_running", {31'd0, running}, 0);

      for (int i = 0; i < 4; i++) plan[i] = 3;
      resp_idx = 0;
      chk_idx = 0;
      d0 = done_cnt;
      @(posedge clk);
      #1;
      num_bytes = 16'd4;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int k = 0; k < 2000 && chk_idx < 3; k++) begin
         @(posedge clk);
         #1;
      end
      chk("reached_byte2", chk_idx, 3);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrun_reset");
      exp_led = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("no_done_after_reset", done_cnt, d0);
      run_test(2, 0, 1'b0, 1'b0);
      chk("lit_after_reset_pass", {31'd0, pass}, 1);

      for (int r = 0; r < 10; r++) begin
         run_test($urandom_range(1, 8), 1, 1'b0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
